// File: rtl/doa_smoother.sv
// Filters per-frame DOA estimates: range/outlier rejection, then a DEPTH-deep moving average.
// Latency: weightdone at edge t gives avg_valid between edges t+3 and t+4. A weightdone during processing is dropped and flagged in overrun.
module doa_smoother #(
  parameter int DEPTH        = 8,
  parameter int MAX_JUMP     = 30,
  parameter int REJECT_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       weightdone,
  input  logic [7:0]                 doa,
  input  logic                       clear,
  output logic [7:0]                 doa_avg,
  output logic                       avg_valid,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [7:0]                 rejects,
  output logic                       overrun
);

  localparam int LOG2D = $clog2(DEPTH);
  localparam int SW    = 8 + LOG2D;
  localparam int CW    = $clog2(REJECT_LIMIT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;
  localparam logic [1:0] OUTPUT = 2'd3;

  localparam logic signed [7:0]  DOA_MAX = 8'sd90;
  localparam logic signed [7:0]  DOA_MIN = -8'sd90;
  localparam logic signed [8:0]  JUMP9   = 9'(MAX_JUMP);
  localparam logic [LOG2D:0]     FULL    = (LOG2D + 1)'(DEPTH);
  localparam logic signed [SW-1:0] HALF  = SW'(DEPTH / 2);
  localparam logic [CW-1:0]      CLIMIT  = CW'(REJECT_LIMIT);

  logic [1:0]              state_q, state_d;
  logic signed [7:0]       s_q, s_d;
  logic signed [SW-1:0]    sum_q, sum_d;
  logic [LOG2D-1:0]        wr_ptr_q, wr_ptr_d;
  logic [LOG2D:0]          fill_q, fill_d;
  logic [CW-1:0]           consec_q, consec_d;
  logic [7:0]              rejects_q, rejects_d;
  logic                    overrun_q, overrun_d;
  logic signed [7:0]       avg_q, avg_d;
  logic                    avg_valid_q, avg_valid_d;
  logic signed [7:0]       ring_q [DEPTH];
  logic                    ring_we;

  logic                    flush;
  logic signed [8:0]       diff;
  logic                    out_of_range;
  logic                    outlier;
  logic [CW-1:0]           consec_inc;
  logic [7:0]              rejects_inc;
  logic signed [SW-1:0]    s_ext;
  logic signed [SW-1:0]    old_ext;
  logic signed [SW-1:0]    rounded;
  logic signed [SW-1:0]    shifted;

  assign flush        = reset | clear;
  assign diff         = {s_q[7], s_q} - {avg_q[7], avg_q};
  assign out_of_range = (s_q < DOA_MIN) || (s_q > DOA_MAX);
  assign outlier      = (fill_q != '0) && ((diff > JUMP9) || (diff < -JUMP9));
  assign consec_inc   = consec_q + 1'b1;
  assign rejects_inc  = (rejects_q == 8'hFF) ? rejects_q : rejects_q + 8'd1;
  assign s_ext        = {{LOG2D{s_q[7]}}, s_q};
  assign old_ext      = {{LOG2D{ring_q[wr_ptr_q][7]}}, ring_q[wr_ptr_q]};
  // Bias by half a step so the arithmetic shift rounds half toward +inf.
  assign rounded      = sum_q + HALF;
  assign shifted      = rounded >>> LOG2D;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    consec_d    = consec_q;
    rejects_d   = rejects_q;
    overrun_d   = overrun_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    ring_we     = 1'b0;

    if (weightdone && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (weightdone) begin
          s_d     = doa;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (out_of_range) begin
          rejects_d = rejects_inc;
          state_d   = IDLE;
        end else if (outlier) begin
          rejects_d = rejects_inc;
          if (consec_inc == CLIMIT) begin
            // Persistent disagreement: the old window is stale, re-seed from this sample.
            fill_d   = '0;
            sum_d    = '0;
            wr_ptr_d = '0;
            consec_d = '0;
            state_d  = UPDATE;
          end else begin
            consec_d = consec_inc;
            state_d  = IDLE;
          end
        end else begin
          consec_d = '0;
          state_d  = UPDATE;
        end
      end
      UPDATE: begin
        if (fill_q == FULL) begin
          sum_d = sum_q - old_ext + s_ext;
        end else begin
          sum_d  = sum_q + s_ext;
          fill_d = fill_q + 1'b1;
        end
        ring_we  = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        state_d  = OUTPUT;
      end
      OUTPUT: begin
        if (fill_q < FULL) begin
          avg_d = s_q;
        end else begin
          avg_d = shifted[7:0];
        end
        avg_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state_q     <= IDLE;
      s_q         <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      consec_q    <= '0;
      rejects_q   <= '0;
      overrun_q   <= 1'b0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      consec_q    <= consec_d;
      rejects_q   <= rejects_d;
      overrun_q   <= overrun_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  // Ring contents need no reset: fill gates every read of a stale slot.
  always_ff @(posedge clk) begin
    if (ring_we && !flush) begin
      ring_q[wr_ptr_q] <= s_q;
    end
  end

  assign doa_avg   = avg_q;
  assign avg_valid = avg_valid_q;
  assign fill      = fill_q;
  assign rejects   = rejects_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/doa_smoother.md
Name: doa_smoother

Overview:
- Post-processing stage directly downstream of the weight block.
- Consumes each per-frame direction-of-arrival estimate (signed degrees, -90..90) on the weight block's done pulse and rejects out-of-range values and sudden outliers.
- Maintains a DEPTH-deep moving average and publishes a smoothed DOA with a one-cycle valid strobe, for the Avalon readback and the VGA marker logic.
- One instance per axis (X and Y).

Parameters:
- DEPTH, 8, moving-average window length; power of two, 2..16; LOG2D = log2(DEPTH).
- MAX_JUMP, 30, max allowed |doa - doa_avg| in degrees for a sample to be accepted once the buffer is non-empty.
- REJECT_LIMIT, 3, consecutive outlier rejects that force a flush and re-seed.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- weightdone  in  1  one-cycle pulse: doa is valid
- doa  in  8  signed DOA estimate, two's complement
- clear  in  1  synchronous flush request, same effect as reset
- doa_avg  out  8  signed smoothed DOA
- avg_valid  out  1  one-cycle strobe: doa_avg updated
- fill  out  LOG2D+1  number of accepted samples in window, 0..DEPTH
- rejects  out  8  total rejected samples, saturates at 255
- overrun  out  1  sticky: weightdone arrived while busy

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset or clear (sampled on a rising edge) takes priority over everything. It forces:
  - state IDLE
  - doa_avg=0, avg_valid=0, fill=0, rejects=0, overrun=0
  - internal sum=0, wr_ptr=0, consec=0
- A weightdone coincident with reset or clear is discarded.
- Storage:
  - DEPTH x 8 signed register ring buffer, written at wr_ptr; wr_ptr wraps modulo DEPTH.
  - Running sum is signed, 8+LOG2D bits. Max |sum| is 90*DEPTH, so it never overflows.
- FSM states: IDLE, CHECK, UPDATE, OUTPUT.
- IDLE:
  - On weightdone=1, latch doa into s, then go to CHECK.
- CHECK: evaluate two reject conditions.
  - Out of range (s < -90 or s > 90):
    - reject: rejects++ (saturating); consec unchanged.
    - Go to IDLE.
  - Outlier (fill > 0 and |s - doa_avg| > MAX_JUMP, difference computed in 9-bit signed):
    - reject: rejects++, consec++.
    - If consec reaches REJECT_LIMIT: flush (fill=0, sum=0, wr_ptr=0, consec=0), then go to UPDATE so s becomes the first sample.
    - Otherwise go to IDLE.
  - Else accept: consec=0, go to UPDATE.
- UPDATE:
  - If fill == DEPTH: sum <= sum - buf[wr_ptr] + s.
  - Else: sum <= sum + s and fill++.
  - buf[wr_ptr] <= s; wr_ptr++. Go to OUTPUT.
- OUTPUT:
  - If fill < DEPTH: doa_avg <= last accepted sample.
  - Else: doa_avg <= (sum + DEPTH/2) >>> LOG2D, an arithmetic shift (round half toward +inf), truncated to 8 bits.
  - avg_valid = 1 for exactly this cycle. Go to IDLE.
- Latency: weightdone sampled at edge t gives avg_valid high between edges t+3 and t+4, and the new doa_avg is stable from the same edge. Rejected samples never produce avg_valid.
- weightdone while state != IDLE is ignored and sets overrun=1, which is sticky until reset or clear.
- doa_avg holds its value between updates.
- fill saturates at DEPTH.

Test Plan:
- Reset, then 8 weightdone pulses with doa=10, spaced 10 cycles -> fill 1..8; avg_valid exactly 3 cycles after each pulse; doa_avg=10 throughout; rejects=0.
- Full window of seven 0 and one -4 -> doa_avg=0; replace the oldest 0 with -1 (sum -5) -> doa_avg=-1; eight samples of -90 -> doa_avg=-90.
- Window full at 10; doa=50 twice -> rejects=2, no avg_valid, doa_avg stays 10; third doa=50 -> flush, fill=1, doa_avg=50, avg_valid pulses; doa=45 next -> accepted, fill=2, doa_avg=45.
- doa=91 and doa=-91 (8'hA5) repeated 5 times with window at 10 -> rejects=5, no flush, fill unchanged, no avg_valid.
- weightdone at t and t+1 -> second pulse ignored, overrun=1; only one avg_valid, at t+3.
- Assert clear at t+2 (UPDATE) after weightdone at t -> no avg_valid; all outputs return to 0; next weightdone with doa=20 gives fill=1, doa_avg=20.
